// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among N_REQ byte streams.
// An owner keeps the transmitter until its last byte, a dropped request, or MAX_PKT_LEN bytes.
module uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int MAX_PKT_LEN = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [N_REQ-1:0]   req_i,
  input  logic [8*N_REQ-1:0] req_data_i,
  input  logic [N_REQ-1:0]   req_last_i,
  output logic [N_REQ-1:0]   req_ack_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               tx_start_o,
  output logic [7:0]         tx_din_o,
  input  logic               tx_done_tick_i,
  output logic               trunc_o,
  output logic               busy_o
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_PKT_LEN + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d, own_q, own_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic [N_REQ-1:0] grant_q, grant_d, ack_q, ack_d;
  logic [7:0]       din_q, din_d;
  logic             start_q, start_d, trunc_q, trunc_d, busy_q;
  logic             found;
  logic [IW-1:0]    win, cand;
  int               idx;

  // Search ptr+1, ptr+2, ... so the most recently served requester ranks last.
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = 0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IW'(idx);
      if (!found && req_i[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    din_d   = din_q;
    start_d = 1'b0;
    ack_d   = '0;
    trunc_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          own_d   = win;
          grant_d = N_REQ'(1) << win;
          cnt_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (req_i[own_q]) begin
          din_d   = req_data_i[{own_q, 3'b000} +: 8];
          start_d = 1'b1;
          ack_d   = N_REQ'(1) << own_q;
          last_d  = req_last_i[own_q];
          cnt_d   = cnt_q + CW'(1);
          state_d = S_WAIT;
        end else begin
          grant_d = '0;
          ptr_d   = own_q;
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (tx_done_tick_i) begin
          if (last_q || cnt_q == CW'(MAX_PKT_LEN)) begin
            grant_d = '0;
            ptr_d   = own_q;
            trunc_d = !last_q;
            state_d = S_IDLE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      ptr_q   <= IW'(N_REQ - 1);
      own_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      grant_q <= '0;
      din_q   <= '0;
      start_q <= 1'b0;
      ack_q   <= '0;
      trunc_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      din_q   <= din_d;
      start_q <= start_d;
      ack_q   <= ack_d;
      trunc_q <= trunc_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign grant_o    = grant_q;
  assign req_ack_o  = ack_q;
  assign tx_start_o = start_q;
  assign tx_din_o   = din_q;
  assign trunc_o    = trunc_q;
  assign busy_o     = busy_q;
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter among N_REQ byte-stream requesters, with packet granularity.
- A granted requester keeps the transmitter until it marks its last byte, drops its request, or hits the MAX_PKT_LEN cap.
- Sits between protocol/status sources and the uart_tx instance. Drives the transmitter's start/data inputs and consumes its done tick.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- MAX_PKT_LEN, 16, maximum bytes per grant before forced release (1..255).

Ports:
- clk_i  in  1  system clock
- rstn_i  in  1  reset; synchronous, active-low
- req_i  in  N_REQ  per-requester "byte available" level
- req_data_i  in  8*N_REQ  byte of requester k on bits [8k+7:8k]
- req_last_i  in  N_REQ  presented byte is the last of its packet
- req_ack_o  out  N_REQ  one-cycle pulse: presented byte consumed
- grant_o  out  N_REQ  one-hot current owner; all zero when idle
- tx_start_o  out  1  one-cycle pulse to transmitter, qualifies tx_din_o
- tx_din_o  out  8  byte to transmit; held until the next load
- tx_done_tick_i  in  1  transmitter finished a byte (stop bit sent)
- trunc_o  out  1  one-cycle pulse: grant force-released at MAX_PKT_LEN
- busy_o  out  1  high whenever state is not S_IDLE

Behaviour:
- All outputs are registered.
- Reset (any cycle, including mid-byte or mid-packet) clears: grant_o, req_ack_o, tx_start_o, trunc_o, busy_o, tx_din_o, and the byte counter. State goes to S_IDLE. RR pointer is set to N_REQ-1, so requester 0 wins first.
- A transmitter byte already in flight at reset is not tracked. Its later tx_done_tick_i is ignored in S_IDLE.
- States: S_IDLE, S_LOAD, S_WAIT.
- S_IDLE:
  - If any req_i is high, pick the first set bit searching ptr+1, ptr+2, ... modulo N_REQ.
  - Next cycle: grant_o is one-hot for the winner, byte counter = 0, state goes to S_LOAD.
  - Otherwise stay in S_IDLE.
- S_LOAD, owner g:
  - If req_i[g]=1: next cycle tx_din_o = req_data_i[g], tx_start_o = 1, req_ack_o[g] = 1, last flag = req_last_i[g], counter += 1, state goes to S_WAIT.
  - If req_i[g]=0: next cycle grant_o = 0, ptr = g, state goes to S_IDLE. The requester abandoned its packet; no trunc_o.
- S_WAIT, on tx_done_tick_i:
  - If last flag is set: release (grant_o = 0, ptr = g, S_IDLE).
  - Else if counter == MAX_PKT_LEN: release and pulse trunc_o for one cycle.
  - Else: go to S_LOAD.
  - Without a tick, hold.
  - A tick in the same cycle tx_start_o is high counts as the done tick.
- tx_done_tick_i is ignored in S_IDLE and S_LOAD.
- Latency: req_i rises at cycle t while idle gives grant_o at t+1, and tx_start_o/req_ack_o at t+2.
- Between consecutive bytes of one packet: tick at cycle u gives the next tx_start_o at u+2.
- Handshake: requester must hold req_data_i/req_last_i stable while req_i=1 until it sees req_ack_o. It may present the next byte from the cycle after the ack.
- req_i/req_data_i changes of non-owners have no effect during a grant.
- Fairness: after a release, the just-served requester has lowest priority. With all N_REQ requesting continuously, grants rotate 0,1,2,3,0,...
- Counter width is $clog2(MAX_PKT_LEN+1) and never wraps. It resets at each new grant.
- Exactly one bit of grant_o is set when not idle. req_ack_o is only ever set on the owner's bit.

Test Plan:
- Single packet, N_REQ=4: req 2 sends 0xA5, 0x3C (last on 0x3C), done tick 10 cycles after each start -> grant_o=4'b0100 at t+1; tx_start_o pulses with tx_din_o 0xA5 then 0x3C; two acks on bit 2; grant_o=0 after the second tick.
- Contention: reqs 0,1,3 each send one-byte packets continuously from reset -> grant order 0,1,3,0,1,3; no requester granted twice before the others are served.
- Truncation, MAX_PKT_LEN=4: req 1 never asserts last, 6 bytes queued -> exactly 4 tx_start_o pulses, trunc_o pulses once on the 4th tick, grant released; req 1 re-granted on its next turn with counter restarted.
- Abandon: req 0 drops req_i after its first ack while the byte is in flight -> after the tick, state goes S_LOAD then S_IDLE; no second start; trunc_o stays 0; ptr=0, so a waiting req 1 wins next.
- Reset mid-packet: assert rstn_i=0 for one cycle during S_WAIT of req 3 -> next cycle all outputs 0, busy_o=0; a stray tx_done_tick_i is ignored; with reqs 0 and 3 pending, requester 0 is granted first.
- Timing edge: tx_done_tick_i asserted in the same cycle as tx_start_o for byte 1 of a 2-byte packet -> treated as done; byte 2 start appears 2 cycles later; spurious ticks in S_IDLE produce no outputs.
